// File: rtl/sha256_stream_core.sv
// sha256_stream_core: iterative SHA-256 compression engine with a valid/ready
// word stream input and a parallel 256-bit digest. The caller supplies
// pre-padded 512-bit blocks. H is chained across blocks until a block is
// flagged final with in_last.
//
// Parameters:
//   IN_W  input beat width, 32 or 64. For 64, in_data[63:32] is the earlier word.
//
// Ports:
//   clk, rst           clock and asynchronous active-high reset
//   start              begins a new message; honoured only in IDLE or DONE
//   mode               1 = SHA-224 (only with SHA224_EN, otherwise ignored)
//   in_valid/in_ready  beat handshake; in_data carries one beat
//   in_last            final-block flag, sampled on the block's last beat
//   busy               high in LOAD, ROUND and UPDATE
//   block_done         one-cycle pulse after each block's H update
//   digest_valid       digest is valid; held until the next start
//   digest             H0..H7, H0 in [255:224]
//
// Optional feature macro: SHA224_EN (SHA-224 IV and truncated digest on mode=1).
module sha256_stream_core #(
  parameter int unsigned IN_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            mode,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_data,
  input  logic            in_last,
  output logic            busy,
  output logic            block_done,
  output logic            digest_valid,
  output logic [255:0]    digest
);
  localparam int unsigned WPB    = 512 / IN_W;
  localparam int unsigned NW     = IN_W / 32;
  localparam int unsigned BEAT_W = $clog2(WPB);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ROUND, S_UPDATE, S_DONE} state_e;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV256 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

`ifdef SHA224_EN
  localparam logic [31:0] IV224 [8] = '{
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };
  logic mode_q, mode_d;
`else
  logic unused_mode;
  assign unused_mode = mode;
`endif

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction
  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction
  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  state_e              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [5:0]          rnd_q, rnd_d;
  logic                final_q, final_d;
  logic [31:0]         w_q [16];
  logic [31:0]         w_d [16];
  logic [31:0]         v_q [8];   // working variables a..h
  logic [31:0]         v_d [8];
  logic [31:0]         h_q [8];
  logic [31:0]         h_d [8];
  logic [255:0]        digest_q, digest_d;
  logic                in_ready_q, in_ready_d;
  logic                busy_q, busy_d;
  logic                block_done_q, block_done_d;
  logic                digest_valid_q, digest_valid_d;
  logic [31:0]         t1, t2;

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d        = state_q;
    beat_d         = beat_q;
    rnd_d          = rnd_q;
    final_d        = final_q;
    w_d            = w_q;
    v_d            = v_q;
    h_d            = h_q;
    digest_d       = digest_q;
    in_ready_d     = 1'b0;
    busy_d         = 1'b0;
    block_done_d   = 1'b0;
    digest_valid_d = 1'b0;
    t1             = '0;
    t2             = '0;
`ifdef SHA224_EN
    mode_d         = mode_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LOAD;
          beat_d  = '0;
          for (int i = 0; i < 8; i++) h_d[i] = IV256[i];
`ifdef SHA224_EN
          mode_d = mode;
          if (mode) for (int i = 0; i < 8; i++) h_d[i] = IV224[i];
`endif
        end
      end
      S_LOAD: begin
        if (in_valid && in_ready_q) begin
          for (int j = 0; j < int'(NW); j++)
            w_d[4'(int'(beat_q) * int'(NW) + j)] = in_data[IN_W-1-32*j -: 32];
          if (beat_q == BEAT_W'(WPB - 1)) begin
            beat_d  = '0;
            rnd_d   = '0;
            final_d = in_last;
            v_d     = h_q;
            state_d = S_ROUND;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      S_ROUND: begin
        t1 = v_q[7] + bsig1(v_q[4]) + ((v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6])) + K[rnd_q] + w_q[0];
        t2 = bsig0(v_q[0]) + ((v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]));
        v_d[7] = v_q[6];
        v_d[6] = v_q[5];
        v_d[5] = v_q[4];
        v_d[4] = v_q[3] + t1;
        v_d[3] = v_q[2];
        v_d[2] = v_q[1];
        v_d[1] = v_q[0];
        v_d[0] = t1 + t2;
        // Window always holds W[t..t+15]; the head is consumed each round
        for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
        w_d[15] = ssig1(w_q[14]) + w_q[9] + ssig0(w_q[1]) + w_q[0];
        rnd_d = rnd_q + 6'd1;
        if (rnd_q == 6'd63) state_d = S_UPDATE;
      end
      S_UPDATE: begin
        for (int i = 0; i < 8; i++) h_d[i] = h_q[i] + v_q[i];
        if (final_q) begin
          state_d = S_DONE;
          for (int i = 0; i < 8; i++) digest_d[255-32*i -: 32] = h_q[i] + v_q[i];
`ifdef SHA224_EN
          if (mode_q) digest_d[31:0] = '0;
`endif
        end else begin
          state_d = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d     = (state_d == S_LOAD);
    busy_d         = (state_d == S_LOAD) || (state_d == S_ROUND) || (state_d == S_UPDATE);
    block_done_d   = (state_q == S_UPDATE);
    // A start accepted in DONE drops digest_valid on the same edge
    digest_valid_d = (state_q == S_DONE) && (state_d == S_DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      beat_q         <= '0;
      rnd_q          <= '0;
      final_q        <= 1'b0;
      w_q            <= '{default: '0};
      v_q            <= '{default: '0};
      h_q            <= '{default: '0};
      digest_q       <= '0;
      in_ready_q     <= 1'b0;
      busy_q         <= 1'b0;
      block_done_q   <= 1'b0;
      digest_valid_q <= 1'b0;
`ifdef SHA224_EN
      mode_q         <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      beat_q         <= beat_d;
      rnd_q          <= rnd_d;
      final_q        <= final_d;
      w_q            <= w_d;
      v_q            <= v_d;
      h_q            <= h_d;
      digest_q       <= digest_d;
      in_ready_q     <= in_ready_d;
      busy_q         <= busy_d;
      block_done_q   <= block_done_d;
      digest_valid_q <= digest_valid_d;
`ifdef SHA224_EN
      mode_q         <= mode_d;
`endif
    end
  end

  assign in_ready     = in_ready_q;
  assign busy         = busy_q;
  assign block_done   = block_done_q;
  assign digest_valid = digest_valid_q;
  assign digest       = digest_q;

endmodule
